// File: rtl/pipe_hold_ctrl_pkg.sv
// Purpose : shared FSM encoding, hold-source priority indices and a winner helper for pipe_hold_ctrl.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pipe_hold_ctrl_pkg;

    // FSM encoding, kept as plain constants so legacy tools can consume it.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    // Hold-source priority: lower index wins.
    localparam int HOLD_SRC_N     = 4;
    localparam int HOLD_IDX_JUMP  = 0;
    localparam int HOLD_IDX_CLINT = 1;
    localparam int HOLD_IDX_BUS   = 2;
    localparam int HOLD_IDX_EX    = 3;

    // Returned by hold_winner when no source is requesting.
    localparam logic [2:0] HOLD_SRC_NONE = 3'd4;

    // Index of the highest-priority active request, or HOLD_SRC_NONE.
    function automatic logic [2:0] hold_winner(input logic [HOLD_SRC_N-1:0] req);
        logic [2:0] win;
        win = HOLD_SRC_NONE;
        for (int i = HOLD_SRC_N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = 3'(i);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// Purpose : request/strobe bundle between the EX/bus/CLINT requesters and the pipeline hold controller.
// Latency : n/a (wires only).
// Backpressure: n/a; stall requests are levels, strobes are combinational from the controller.
// Ports   : slave = controller side (requests in, strobes out); master = requester/pipeline side.
interface pipe_hold_ctrl_if #(
    parameter int AW = 32
);
    logic          jump_req_i;
    logic [AW-1:0] jump_addr_i;
    logic          hold_ex_i;
    logic          hold_bus_i;
    logic          hold_clint_i;
    logic          jump_o;
    logic [AW-1:0] jump_addr_o;
    logic          pc_hold_o;
    logic          if_id_flush_o;
    logic          id_ex_flush_o;
    logic          busy_o;

    modport slave (
        input  jump_req_i, jump_addr_i, hold_ex_i, hold_bus_i, hold_clint_i,
        output jump_o, jump_addr_o, pc_hold_o, if_id_flush_o, id_ex_flush_o, busy_o
    );

    modport master (
        output jump_req_i, jump_addr_i, hold_ex_i, hold_bus_i, hold_clint_i,
        input  jump_o, jump_addr_o, pc_hold_o, if_id_flush_o, id_ex_flush_o, busy_o
    );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Purpose : W-bit event counter that sticks at all-ones instead of wrapping.
// Latency : count visible one cycle after the inc_i cycle.
// Backpressure: none; inc_i is sampled every cycle.
// Ports   : clk, rst (sync, active-high, clears count), inc_i (count this cycle), cnt_o (current count).
module pipe_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hold_ctrl.sv
// Purpose : central pipeline hold/flush controller; arbitrates EX redirects against EX/bus/CLINT stalls.
// Latency : all strobes are combinational in the request cycle; busy_o is registered (state != RUN).
// Backpressure: stalls hold the PC and bubble IF/ID and ID/EX; a redirect is never blocked by a stall.
// Ports   : clk, rst (sync, active-high); hc (slave modport of pipe_hold_ctrl_if).
//           With PIPE_HOLD_CTRL_PERF_EN defined: flush_cnt_o / stall_cnt_o saturating event counters.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int AW        = 32,
    parameter int FLUSH_CYC = 2      // front-end flush window after a redirect, 1..15
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hold_ctrl_if.slave   hc
`ifdef PIPE_HOLD_CTRL_PERF_EN
    ,
    output logic [31:0]       flush_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);
    localparam int CW = $clog2(FLUSH_CYC + 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(FLUSH_CYC - 1);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;

    logic [HOLD_SRC_N-1:0] req;
    logic [2:0]            winner;
    logic                  jump_acc;
    logic                  stall_any;
    logic                  state_after_win;

    logic                  jump_o;
    logic [AW-1:0]         jump_addr_o;
    logic                  pc_hold_o;
    logic                  flush_o;
    logic                  busy_o;

    // Request vector and arbitration.
    always_comb begin
        req                 = '0;
        req[HOLD_IDX_JUMP]  = hc.jump_req_i;
        req[HOLD_IDX_CLINT] = hc.hold_clint_i;
        req[HOLD_IDX_BUS]   = hc.hold_bus_i;
        req[HOLD_IDX_EX]    = hc.hold_ex_i;
        winner              = hold_winner(req);
        jump_acc            = (winner == 3'(HOLD_IDX_JUMP));
        stall_any           = hc.hold_ex_i | hc.hold_bus_i | hc.hold_clint_i;
        // Where the FSM lands once a flush window is over (or skipped).
        state_after_win     = stall_any;
    end

    // Next-state / flush-window counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (jump_acc) begin
            // A redirect wins from any state and (re)opens the flush window.
            if (FLUSH_CYC > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_RELOAD;
            end else begin
                state_d = state_after_win ? ST_STALL : ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    state_d = stall_any ? ST_STALL : ST_RUN;
                end
                ST_FLUSH: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = state_after_win ? ST_STALL : ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CW'(1);
                    end
                end
                ST_STALL: begin
                    state_d = stall_any ? ST_STALL : ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output strobes. During reset the whole front end is held and bubbled
    // and no redirect escapes, so a stale jump cannot steer the fresh PC.
    always_comb begin
        jump_o      = 1'b0;
        jump_addr_o = '0;
        pc_hold_o   = 1'b0;
        flush_o     = 1'b0;
        busy_o      = 1'b0;
        if (rst) begin
            pc_hold_o = 1'b1;
            flush_o   = 1'b1;
        end else begin
            busy_o = (state_q != ST_RUN);
            if (jump_acc) begin
                jump_o      = 1'b1;
                jump_addr_o = hc.jump_addr_i;
                flush_o     = 1'b1;
            end
            case (state_q)
                ST_FLUSH: begin
                    flush_o   = 1'b1;
                    pc_hold_o = stall_any;
                end
                // RUN and STALL both follow the stall level combinationally:
                // RUN enters the hold in the request cycle, STALL releases it
                // in the first cycle the request drops.
                default: begin
                    if (stall_any) begin
                        pc_hold_o = 1'b1;
                        flush_o   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign hc.jump_o        = jump_o;
    assign hc.jump_addr_o   = jump_addr_o;
    assign hc.pc_hold_o     = pc_hold_o;
    assign hc.if_id_flush_o = flush_o;
    assign hc.id_ex_flush_o = flush_o;
    assign hc.busy_o        = busy_o;

`ifdef PIPE_HOLD_CTRL_PERF_EN
    // Flush cycles: redirect cycle or inside the flush window.
    // Stall cycles: a stall is holding the pipe and no flush is in progress.
    logic flush_ev;
    logic stall_ev;

    always_comb begin
        flush_ev = jump_acc | (state_q == ST_FLUSH);
        stall_ev = stall_any & ~flush_ev;
    end

    pipe_sat_cnt #(.W(32)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_ev),
        .cnt_o (flush_cnt_o)
    );

    pipe_sat_cnt #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_ev),
        .cnt_o (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Purpose : directed self-checking bench for pipe_hold_ctrl (FLUSH_CYC=2 and FLUSH_CYC=3 instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_pipe_hold_ctrl;
    import pipe_hold_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipe_hold_ctrl_if #(.AW(32)) if2 ();
    pipe_hold_ctrl_if #(.AW(32)) if3 ();

`ifdef PIPE_HOLD_CTRL_PERF_EN
    logic [31:0] fc2, sc2, fc3, sc3;
`endif

    pipe_hold_ctrl #(.AW(32), .FLUSH_CYC(2)) d2 (
        .clk (clk),
        .rst (rst),
        .hc  (if2)
`ifdef PIPE_HOLD_CTRL_PERF_EN
        ,
        .flush_cnt_o (fc2),
        .stall_cnt_o (sc2)
`endif
    );

    pipe_hold_ctrl #(.AW(32), .FLUSH_CYC(3)) d3 (
        .clk (clk),
        .rst (rst),
        .hc  (if3)
`ifdef PIPE_HOLD_CTRL_PERF_EN
        ,
        .flush_cnt_o (fc3),
        .stall_cnt_o (sc3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait one clock, then apply the inputs to both instances and settle to the negedge.
    task automatic dv(input logic j, input logic [31:0] a, input logic ex,
                      input logic bus, input logic cl, input logic r);
        @(posedge clk);
        #1;
        rst              = r;
        if2.jump_req_i   = j;   if3.jump_req_i   = j;
        if2.jump_addr_i  = a;   if3.jump_addr_i  = a;
        if2.hold_ex_i    = ex;  if3.hold_ex_i    = ex;
        if2.hold_bus_i   = bus; if3.hold_bus_i   = bus;
        if2.hold_clint_i = cl;  if3.hold_clint_i = cl;
        @(negedge clk);
    endtask

    // Check all strobes of instance d (2 or 3).
    task automatic ck(input int d, input string tag, input logic j, input logic [31:0] a,
                      input logic pch, input logic fl, input logic busy);
        if (d == 2) begin
            chk({tag, ".jump"},  32'(if2.jump_o),        32'(j));
            chk({tag, ".addr"},  if2.jump_addr_o,        a);
            chk({tag, ".pch"},   32'(if2.pc_hold_o),     32'(pch));
            chk({tag, ".ifid"},  32'(if2.if_id_flush_o), 32'(fl));
            chk({tag, ".idex"},  32'(if2.id_ex_flush_o), 32'(fl));
            chk({tag, ".busy"},  32'(if2.busy_o),        32'(busy));
        end else begin
            chk({tag, ".jump"},  32'(if3.jump_o),        32'(j));
            chk({tag, ".addr"},  if3.jump_addr_o,        a);
            chk({tag, ".pch"},   32'(if3.pc_hold_o),     32'(pch));
            chk({tag, ".ifid"},  32'(if3.if_id_flush_o), 32'(fl));
            chk({tag, ".idex"},  32'(if3.id_ex_flush_o), 32'(fl));
            chk({tag, ".busy"},  32'(if3.busy_o),        32'(busy));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        if2.jump_req_i = 1'b0; if2.jump_addr_i = '0; if2.hold_ex_i = 1'b0;
        if2.hold_bus_i = 1'b0; if2.hold_clint_i = 1'b0;
        if3.jump_req_i = 1'b0; if3.jump_addr_i = '0; if3.hold_ex_i = 1'b0;
        if3.hold_bus_i = 1'b0; if3.hold_clint_i = 1'b0;

        // Reset held 3 cycles; a jump request during reset must not escape.
        dv(0, 0, 0, 0, 0, 1); ck(2, "rst0", 0, 0, 1, 1, 0);
        dv(0, 0, 0, 0, 0, 1); ck(2, "rst1", 0, 0, 1, 1, 0);
        dv(1, 32'hDEAD, 0, 0, 0, 1); ck(2, "rst2", 0, 0, 1, 1, 0);
        dv(0, 0, 0, 0, 0, 0); ck(2, "idle", 0, 0, 0, 0, 0); ck(3, "idle3", 0, 0, 0, 0, 0);

        // Single jump, FLUSH_CYC=2: flush cycles 0 and 1.
        dv(1, 32'h100, 0, 0, 0, 0); ck(2, "jmp0", 1, 32'h100, 0, 1, 0);
        dv(0, 0, 0, 0, 0, 0);       ck(2, "jmp1", 0, 0, 0, 1, 1);
        dv(0, 0, 0, 0, 0, 0);       ck(2, "jmp2", 0, 0, 0, 0, 0);
        dv(0, 0, 0, 0, 0, 0);

        // EX stall for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            dv(0, 0, 1, 0, 0, 0); ck(2, "ex", 0, 0, 1, 1, (i == 0) ? 1'b0 : 1'b1);
        end
        dv(0, 0, 0, 0, 0, 0); ck(2, "ex_rel", 0, 0, 0, 0, 1);
        dv(0, 0, 0, 0, 0, 0); ck(2, "ex_done", 0, 0, 0, 0, 0);

        // Jump in the 2nd cycle of a steady bus stall: STALL -> FLUSH -> STALL.
        dv(0, 0, 0, 1, 0, 0);           ck(2, "bs0", 0, 0, 1, 1, 0);
        dv(1, 32'h200, 0, 1, 0, 0);     ck(2, "bs1", 1, 32'h200, 1, 1, 1);
        dv(0, 0, 0, 1, 0, 0);           ck(2, "bs2", 0, 0, 1, 1, 1);
        chk("bs2.state", 32'(d2.state_q), 32'(ST_FLUSH));
        dv(0, 0, 0, 1, 0, 0);           ck(2, "bs3", 0, 0, 1, 1, 1);
        chk("bs3.state", 32'(d2.state_q), 32'(ST_STALL));
        dv(0, 0, 0, 1, 0, 0);           ck(2, "bs4", 0, 0, 1, 1, 1);
        dv(0, 0, 0, 0, 0, 0);           ck(2, "bs_rel", 0, 0, 0, 0, 1);
        dv(0, 0, 0, 0, 0, 0);           ck(2, "bs_done", 0, 0, 0, 0, 0);

        // Jump and CLINT together: jump wins, CLINT stall follows the window.
        dv(1, 32'h400, 0, 0, 1, 0);     ck(2, "jc0", 1, 32'h400, 1, 1, 0);
        dv(0, 0, 0, 0, 1, 0);           ck(2, "jc1", 0, 0, 1, 1, 1);
        chk("jc1.state", 32'(d2.state_q), 32'(ST_FLUSH));
        dv(0, 0, 0, 0, 1, 0);           ck(2, "jc2", 0, 0, 1, 1, 1);
        chk("jc2.state", 32'(d2.state_q), 32'(ST_STALL));
        dv(0, 0, 0, 0, 0, 0);           ck(2, "jc3", 0, 0, 0, 0, 1);
        dv(0, 0, 0, 0, 0, 0);           ck(2, "jc4", 0, 0, 0, 0, 0); ck(3, "jc4_3", 0, 0, 0, 0, 0);

        // Back-to-back jumps: window reloads (FLUSH_CYC=3 and 2).
        dv(1, 32'h300, 0, 0, 0, 0); ck(3, "bb0", 1, 32'h300, 0, 1, 0); ck(2, "bb0_2", 1, 32'h300, 0, 1, 0);
        dv(1, 32'h304, 0, 0, 0, 0); ck(3, "bb1", 1, 32'h304, 0, 1, 1); ck(2, "bb1_2", 1, 32'h304, 0, 1, 1);
        dv(0, 0, 0, 0, 0, 0);       ck(3, "bb2", 0, 0, 0, 1, 1);       ck(2, "bb2_2", 0, 0, 0, 1, 1);
        dv(0, 0, 0, 0, 0, 0);       ck(3, "bb3", 0, 0, 0, 1, 1);       ck(2, "bb3_2", 0, 0, 0, 0, 0);
        dv(0, 0, 0, 0, 0, 0);       ck(3, "bb4", 0, 0, 0, 0, 0);

        // Reset in cycle 1 of a FLUSH_CYC=3 window: no residual flush.
        dv(1, 32'h500, 0, 0, 0, 0); ck(3, "rm0", 1, 32'h500, 0, 1, 0);
        dv(0, 0, 0, 0, 0, 1);       ck(3, "rm1", 0, 0, 1, 1, 0);
        dv(0, 0, 0, 0, 0, 0);       ck(3, "rm2", 0, 0, 0, 0, 0);
        chk("rm2.state", 32'(d3.state_q), 32'(ST_RUN));
        dv(0, 0, 0, 0, 0, 0);       ck(3, "rm3", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
